// File: rtl/dieroll_pkg.sv
// Shared types and constants for the dieroller roll arbiter: FSM states,
// die-select encoding, die geometry helpers and LFSR constants.
package dieroll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TUMBLE,
    ST_REDUCE,
    ST_DONE
  } state_t;

  localparam logic [2:0] SEL_D2   = 3'd0;
  localparam logic [2:0] SEL_D4   = 3'd1;
  localparam logic [2:0] SEL_D6   = 3'd2;
  localparam logic [2:0] SEL_D8   = 3'd3;
  localparam logic [2:0] SEL_D10  = 3'd4;
  localparam logic [2:0] SEL_D12  = 3'd5;
  localparam logic [2:0] SEL_D20  = 3'd6;
  localparam logic [2:0] SEL_D100 = 3'd7;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [6:0] die_sides(input logic [2:0] sel);
    case (sel)
      SEL_D2:   die_sides = 7'd2;
      SEL_D4:   die_sides = 7'd4;
      SEL_D6:   die_sides = 7'd6;
      SEL_D8:   die_sides = 7'd8;
      SEL_D10:  die_sides = 7'd10;
      SEL_D12:  die_sides = 7'd12;
      SEL_D20:  die_sides = 7'd20;
      SEL_D100: die_sides = 7'd100;
      default:  die_sides = 7'd2;
    endcase
  endfunction

  // Fewest LFSR bits whose range covers the die; always < 2*sides.
  function automatic logic [2:0] die_bits(input logic [2:0] sel);
    case (sel)
      SEL_D2:   die_bits = 3'd1;
      SEL_D4:   die_bits = 3'd2;
      SEL_D6:   die_bits = 3'd3;
      SEL_D8:   die_bits = 3'd3;
      SEL_D10:  die_bits = 3'd4;
      SEL_D12:  die_bits = 3'd4;
      SEL_D20:  die_bits = 3'd5;
      SEL_D100: die_bits = 3'd7;
      default:  die_bits = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dieroll_lfsr.sv
// 16-bit right-shifting Galois LFSR; holds its state while disabled.
module dieroll_lfsr
  import dieroll_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ena,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LFSR_SEED;
    end else if (i_ena) begin
      r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/dieroll_arbiter.sv
// Round-robin owner of the shared die-roll engine: grants one requester,
// tumbles for a fixed interval, then reduces LFSR samples to a die face.
module dieroll_arbiter
  import dieroll_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int TUMBLE_CYCLES = 8,
  parameter int MAX_RETRY     = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      sides_sel,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            tumble,
  output logic            result_valid,
  output logic [6:0]      result,
  output logic [1:0]      result_owner
);

  state_t r_state, w_next;

  logic [1:0]  r_rr, r_owner, r_result_owner;
  logic [2:0]  r_sel;
  logic [7:0]  r_tcnt;
  logic [3:0]  r_retry;
  logic [6:0]  r_result;

  logic [15:0]       w_lfsr;
  logic              w_unused_lfsr;
  logic [2*NREQ-1:0] w_rot;
  logic [1:0]        w_pos, w_pick_idx;
  logic [2:0]        w_sum;
  logic              w_start, w_tumble_end, w_accept, w_last_try;
  logic [2:0]        w_bits;
  logic [6:0]        w_sides, w_mask, w_v;
  logic [NREQ-1:0]   w_gnt_onehot;

  dieroll_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_ena   (ena),
    .o_state (w_lfsr)
  );

  // Only the low bits are ever sampled for a die face.
  assign w_unused_lfsr = ^w_lfsr[15:7];

  // Rotate requests so bit 0 is the rr pointer; lowest set bit wins.
  assign w_rot = {req, req} >> r_rr;

  always_comb begin
    w_pos = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = 2'(i);
    end
  end

  assign w_sum      = {1'b0, r_rr} + {1'b0, w_pos};
  assign w_pick_idx = (w_sum >= 3'(NREQ)) ? 2'(w_sum - 3'(NREQ)) : w_sum[1:0];

  assign w_start      = (r_state == ST_IDLE) && ena && (|req);
  assign w_tumble_end = (r_tcnt == 8'(TUMBLE_CYCLES - 1));

  assign w_bits     = die_bits(r_sel);
  assign w_sides    = die_sides(r_sel);
  assign w_mask     = (7'd1 << w_bits) - 7'd1;
  assign w_v        = w_lfsr[6:0] & w_mask;
  assign w_accept   = (w_v < w_sides);
  assign w_last_try = (r_retry == 4'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = ST_TUMBLE;
      ST_TUMBLE: if (w_tumble_end) w_next = ST_REDUCE;
      ST_REDUCE: if (w_accept || w_last_try) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

  always_comb begin
    gnt          = '0;
    busy         = 1'b0;
    tumble       = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      ST_TUMBLE: begin
        gnt    = w_gnt_onehot;
        busy   = 1'b1;
        tumble = 1'b1;
      end
      ST_REDUCE: begin
        gnt  = w_gnt_onehot;
        busy = 1'b1;
      end
      ST_DONE: begin
        gnt          = w_gnt_onehot;
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr           <= '0;
      r_owner        <= '0;
      r_sel          <= '0;
      r_tcnt         <= '0;
      r_retry        <= '0;
      r_result       <= '0;
      r_result_owner <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_owner <= w_pick_idx;
            r_sel   <= sides_sel;
            r_tcnt  <= '0;
            r_retry <= '0;
          end
        end
        ST_TUMBLE: r_tcnt <= r_tcnt + 8'd1;
        ST_REDUCE: begin
          if (w_accept) begin
            r_result       <= w_v + 7'd1;
            r_result_owner <= r_owner;
          end else if (w_last_try) begin
            // v < 2*sides, so folding once always lands in 1..sides.
            r_result       <= w_v - w_sides + 7'd1;
            r_result_owner <= r_owner;
          end else begin
            r_retry <= r_retry + 4'd1;
          end
        end
        ST_DONE: r_rr <= (r_owner == 2'(NREQ - 1)) ? 2'd0 : r_owner + 2'd1;
        default: ;
      endcase
    end
  end

  assign result       = r_result;
  assign result_owner = r_result_owner;

endmodule
